cache_control: RTL and testbench

CACHE_CONTROL -- requirements
Module: cache_control

---
 rtl/cache_control.sv | 167 ++++++++++++++++
 tb/tb_cache_control.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_control.sv
// rtl/cache_control.sv - two-way set-associative cache controller (hit / writeback / allocate)
//
// Purpose:
//   Sequences CPU requests against a two-way cache datapath. Hits complete in
//   the IDLE cycle they are presented. Misses write back a dirty victim if
//   needed, fetch the block from physical memory, fill the victim way, then
//   return to IDLE where the request completes as an ordinary hit.
//   Saturating hit/miss performance counters are kept alongside.
//
// Ports:
//   clk, reset_n                     clock, asynchronous active-low reset
//   mem_read, mem_write, mem_resp    CPU request / one-cycle completion
//   ishit0_out, ishit1_out           per-way tag hit from the datapath
//   dirtyarr0_out, dirtyarr1_out     per-way dirty bit at the current index
//   lru_out                          victim way at the current index
//   datainmux_sel                    0 = pmem_rdata, 1 = merged CPU write block
//   addressmux_sel                   0 = CPU, 1 = way0 writeback, 2 = way1 writeback
//   *_write strobes                  datapath array write enables
//   pmem_read, pmem_write, pmem_resp physical memory handshake
//   hit_count, miss_count            saturating performance counters

module cache_control #(
   parameter int CNT_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 mem_read,
   input  logic                 mem_write,
   output logic                 mem_resp,
   input  logic                 ishit0_out,
   input  logic                 ishit1_out,
   input  logic                 dirtyarr0_out,
   input  logic                 dirtyarr1_out,
   input  logic                 lru_out,
   output logic                 datainmux_sel,
   output logic [1:0]           addressmux_sel,
   output logic                 dataarr0_write,
   output logic                 dataarr1_write,
   output logic                 tag0_write,
   output logic                 tag1_write,
   output logic                 valid0_write,
   output logic                 valid1_write,
   output logic                 dirtyarr0_write,
   output logic                 dirtyarr1_write,
   output logic                 lru_write,
   output logic                 pmem_read,
   output logic                 pmem_write,
   input  logic                 pmem_resp,
   output logic [CNT_WIDTH-1:0] hit_count,
   output logic [CNT_WIDTH-1:0] miss_count
);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WRITEBACK = 2'd1,
      ALLOCATE  = 2'd2
   } state_t;

   localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
   localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

   state_t     state;
   logic       victim_q;       // way chosen at miss time, held for the fill
   logic       pmem_read_q;
   logic       pmem_write_q;
   logic [1:0] addr_sel_q;

   logic req;
   logic hit;
   logic hit_way;              // way0 wins when both ways report a hit
   logic vdirty;
   logic idle_req;
   logic hit_done;
   logic wr_hit;
   logic miss_start;
   logic fill;

   assign req     = mem_read | mem_write;
   assign hit     = ishit0_out | ishit1_out;
   assign hit_way = ~ishit0_out;
   assign vdirty  = lru_out ? dirtyarr1_out : dirtyarr0_out;

   // Combinational strobes are gated with reset_n so an asserted reset
   // silences them immediately, even with a live request on the inputs.
   assign idle_req   = reset_n & (state == IDLE) & req;
   assign hit_done   = idle_req & hit;
   assign wr_hit     = hit_done & mem_write;
   assign miss_start = idle_req & ~hit;
   assign fill       = reset_n & (state == ALLOCATE) & pmem_resp;

   assign mem_resp      = hit_done;
   assign lru_write     = hit_done;
   assign datainmux_sel = wr_hit;

   // A write hit and a fill never coincide (different states), so the
   // shared data/dirty strobes can simply be OR-ed.
   assign dataarr0_write  = (wr_hit & ~hit_way) | (fill & ~victim_q);
   assign dataarr1_write  = (wr_hit &  hit_way) | (fill &  victim_q);
   assign dirtyarr0_write = (wr_hit & ~hit_way) | (fill & ~victim_q);
   assign dirtyarr1_write = (wr_hit &  hit_way) | (fill &  victim_q);
   assign tag0_write      = fill & ~victim_q;
   assign tag1_write      = fill &  victim_q;
   assign valid0_write    = fill & ~victim_q;
   assign valid1_write    = fill &  victim_q;

   assign pmem_read      = pmem_read_q;
   assign pmem_write     = pmem_write_q;
   assign addressmux_sel = addr_sel_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state        <= IDLE;
         victim_q     <= 1'b0;
         pmem_read_q  <= 1'b0;
         pmem_write_q <= 1'b0;
         addr_sel_q   <= 2'd0;
         hit_count    <= '0;
         miss_count   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (miss_start) begin
                  victim_q <= lru_out;
                  if (vdirty) begin
                     state        <= WRITEBACK;
                     pmem_write_q <= 1'b1;
                     addr_sel_q   <= lru_out ? 2'd2 : 2'd1;
                  end else begin
                     state       <= ALLOCATE;
                     pmem_read_q <= 1'b1;
                     addr_sel_q  <= 2'd0;
                  end
               end
            end
            WRITEBACK: begin
               if (pmem_resp) begin
                  state        <= ALLOCATE;
                  pmem_write_q <= 1'b0;
                  pmem_read_q  <= 1'b1;
                  addr_sel_q   <= 2'd0;
               end
            end
            ALLOCATE: begin
               // The fill finishes even if the CPU has withdrawn its request;
               // IDLE then simply sees no request and issues no response.
               if (pmem_resp) begin
                  state       <= IDLE;
                  pmem_read_q <= 1'b0;
                  addr_sel_q  <= 2'd0;
               end
            end
            default: begin
               state        <= IDLE;
               pmem_read_q  <= 1'b0;
               pmem_write_q <= 1'b0;
               addr_sel_q   <= 2'd0;
            end
         endcase

         if (hit_done && (hit_count != CNT_MAX))
            hit_count <= hit_count + CNT_ONE;
         if (miss_start && (miss_count != CNT_MAX))
            miss_count <= miss_count + CNT_ONE;
      end
   end

endmodule

// File: tb/tb_cache_control.sv
// tb/tb_cache_control.sv - scoreboard bench for cache_control with a two-way datapath and memory model

module tb_cache_control;

   localparam int CW      = 2;
   localparam int CNT_SAT = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          mem_read = 1'b0;
   logic          mem_write = 1'b0;
   logic          mem_resp;
   logic          ishit0_out, ishit1_out;
   logic          dirtyarr0_out, dirtyarr1_out;
   logic          lru_out;
   logic          datainmux_sel;
   logic [1:0]    addressmux_sel;
   logic          dataarr0_write, dataarr1_write, tag0_write, tag1_write;
   logic          valid0_write, valid1_write, dirtyarr0_write, dirtyarr1_write;
   logic          lru_write;
   logic          pmem_read, pmem_write;
   logic          pmem_resp = 1'b0;
   logic [CW-1:0] hit_count, miss_count;

   always #5 clk = ~clk;

   cache_control #(.CNT_WIDTH(CW)) dut (
      .clk(clk), .reset_n(reset_n),
      .mem_read(mem_read), .mem_write(mem_write), .mem_resp(mem_resp),
      .ishit0_out(ishit0_out), .ishit1_out(ishit1_out),
      .dirtyarr0_out(dirtyarr0_out), .dirtyarr1_out(dirtyarr1_out),
      .lru_out(lru_out),
      .datainmux_sel(datainmux_sel), .addressmux_sel(addressmux_sel),
      .dataarr0_write(dataarr0_write), .dataarr1_write(dataarr1_write),
      .tag0_write(tag0_write), .tag1_write(tag1_write),
      .valid0_write(valid0_write), .valid1_write(valid1_write),
      .dirtyarr0_write(dirtyarr0_write), .dirtyarr1_write(dirtyarr1_write),
      .lru_write(lru_write),
      .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_resp(pmem_resp),
      .hit_count(hit_count), .miss_count(miss_count)
   );

   // ---------------- single-set datapath model ----------------
   logic [7:0] cpu_tag   = 8'h00;
   logic [1:0] env_valid = 2'b00;
   logic [1:0] env_dirty = 2'b00;
   logic [7:0] env_tag0  = 8'h00;
   logic [7:0] env_tag1  = 8'h00;
   logic       env_lru   = 1'b0;

   assign ishit0_out    = env_valid[0] && (env_tag0 == cpu_tag);
   assign ishit1_out    = env_valid[1] && (env_tag1 == cpu_tag);
   assign dirtyarr0_out = env_dirty[0];
   assign dirtyarr1_out = env_dirty[1];
   assign lru_out       = env_lru;

   always @(posedge clk) begin
      if (tag0_write)      env_tag0     <= cpu_tag;
      if (tag1_write)      env_tag1     <= cpu_tag;
      if (valid0_write)    env_valid[0] <= 1'b1;
      if (valid1_write)    env_valid[1] <= 1'b1;
      if (dirtyarr0_write) env_dirty[0] <= mem_write;
      if (dirtyarr1_write) env_dirty[1] <= mem_write;
      if (lru_write)       env_lru      <= ishit0_out ? 1'b1 : 1'b0;
   end

   // ---------------- physical memory responder ----------------
   // pmem_resp arrives in the mem_lat-th cycle of a held request.
   int mem_lat = 2;
   int rcnt    = 0;

   always @(posedge clk) begin
      if (pmem_resp) begin
         pmem_resp <= 1'b0;
         rcnt      <= 0;
      end else if (pmem_read || pmem_write) begin
         rcnt <= rcnt + 1;
         if (rcnt + 1 == mem_lat - 1) pmem_resp <= 1'b1;
      end else begin
         rcnt <= 0;
      end
   end

   // ---------------- activity monitor ----------------
   int         rd_cyc = 0, wr_cyc = 0, both_cyc = 0, rd_sel_bad = 0;
   int         fill0 = 0, fill1 = 0, fill_bad = 0, resp_cnt = 0;
   logic [1:0] wb_sel_last = 2'd0;

   always @(negedge clk) begin
      if (pmem_read) begin
         rd_cyc <= rd_cyc + 1;
         if (addressmux_sel != 2'd0 || datainmux_sel) rd_sel_bad <= rd_sel_bad + 1;
      end
      if (pmem_write) begin
         wr_cyc      <= wr_cyc + 1;
         wb_sel_last <= addressmux_sel;
      end
      if (pmem_read && pmem_write) both_cyc <= both_cyc + 1;
      if (tag0_write) begin
         fill0 <= fill0 + 1;
         if (!(dataarr0_write && valid0_write && dirtyarr0_write)) fill_bad <= fill_bad + 1;
      end
      if (tag1_write) begin
         fill1 <= fill1 + 1;
         if (!(dataarr1_write && valid1_write && dirtyarr1_write)) fill_bad <= fill_bad + 1;
      end
      if (mem_resp) resp_cnt <= resp_cnt + 1;
   end

   // ---------------- checking ----------------
   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input int actual, input int expected);
      n_checks++;
      if (actual !== expected) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, actual, expected);
      end
   endtask

   // ---------------- reference model + scoreboard ----------------
   typedef struct {
      int   lat;
      int   rd;
      int   wr;
      int   wb_sel;
      int   fill_way;
      int   way;
      logic wr_op;
      int   hits;
      int   misses;
   } exp_t;

   exp_t       exp_q[$];
   logic [1:0] ref_valid = 2'b00;
   logic [1:0] ref_dirty = 2'b00;
   logic [7:0] ref_tag0  = 8'h00;
   logic [7:0] ref_tag1  = 8'h00;
   logic       ref_lru   = 1'b0;
   int         ref_hit   = 0;
   int         ref_miss  = 0;

   function automatic int sat_inc(input int v);
      return (v < CNT_SAT) ? v + 1 : CNT_SAT;
   endfunction

   // Reference handling of a miss: victim fill bookkeeping.
   task automatic ref_miss_fill(inout exp_t e, input logic [7:0] tag, input logic wr, input int lat);
      int v;
      v          = int'(ref_lru);
      e.fill_way = v;
      e.way      = v;
      e.rd       = lat;
      if (ref_dirty[v]) begin
         e.wr     = lat;
         e.wb_sel = v + 1;
      end
      if (v == 0) ref_tag0 = tag; else ref_tag1 = tag;
      ref_valid[v] = 1'b1;
      ref_dirty[v] = wr;
      ref_miss     = sat_inc(ref_miss);
   endtask

   task automatic check_arrays(input string tag);
      check({tag, "_tag0"},  int'(env_tag0),  int'(ref_tag0));
      check({tag, "_tag1"},  int'(env_tag1),  int'(ref_tag1));
      check({tag, "_valid"}, int'(env_valid), int'(ref_valid));
      check({tag, "_dirty"}, int'(env_dirty), int'(ref_dirty));
      check({tag, "_lru"},   int'(env_lru),   int'(ref_lru));
   endtask

   task automatic do_req(input string tag, input logic rd, input logic wr,
                         input logic [7:0] ctag, input int lat);
      exp_t e;
      logic h0, h1, got;
      logic s_lru, s_dmux, s_d0, s_d1, s_y0, s_y1, s_pm;
      int   c, rd0, wr0, f00, f10;
      h0 = ref_valid[0] && (ref_tag0 == ctag);
      h1 = ref_valid[1] && (ref_tag1 == ctag);
      e = '{lat: 1, rd: 0, wr: 0, wb_sel: 0, fill_way: -1, way: 0, wr_op: wr, hits: 0, misses: 0};
      if (h0 || h1) e.way = h0 ? 0 : 1;
      else begin
         ref_miss_fill(e, ctag, wr, lat);
         e.lat = 2 + e.rd + e.wr;
      end
      ref_hit = sat_inc(ref_hit);
      ref_lru = (e.way == 0) ? 1'b1 : 1'b0;
      if (wr) ref_dirty[e.way] = 1'b1;
      e.hits   = ref_hit;
      e.misses = ref_miss;
      exp_q.push_back(e);

      rd0 = rd_cyc; wr0 = wr_cyc; f00 = fill0; f10 = fill1;
      mem_lat = lat;
      {s_lru, s_dmux, s_d0, s_d1, s_y0, s_y1, s_pm} = '0;
      @(posedge clk); #1;
      mem_read = rd; mem_write = wr; cpu_tag = ctag;
      c = 0; got = 1'b0;
      while (!got && c < 100) begin
         @(negedge clk);
         c++;
         if (mem_resp) begin
            got = 1'b1;
            {s_lru, s_dmux, s_d0, s_d1} = {lru_write, datainmux_sel, dataarr0_write, dataarr1_write};
            {s_y0, s_y1, s_pm} = {dirtyarr0_write, dirtyarr1_write, pmem_read | pmem_write};
         end
      end
      @(posedge clk); #1;
      mem_read = 1'b0; mem_write = 1'b0;

      e = exp_q.pop_front();
      check({tag, "_resp_seen"}, int'(got), 1);
      check({tag, "_latency"},   c, e.lat);
      check({tag, "_rd_cycles"}, rd_cyc - rd0, e.rd);
      check({tag, "_wr_cycles"}, wr_cyc - wr0, e.wr);
      if (e.wr > 0) check({tag, "_wb_sel"}, int'(wb_sel_last), e.wb_sel);
      check({tag, "_fill0"}, fill0 - f00, (e.fill_way == 0) ? 1 : 0);
      check({tag, "_fill1"}, fill1 - f10, (e.fill_way == 1) ? 1 : 0);
      check({tag, "_lru_write"}, int'(s_lru), 1);
      check({tag, "_datainmux"}, int'(s_dmux), int'(e.wr_op));
      check({tag, "_dataarr0"},  int'(s_d0), int'(e.wr_op && e.way == 0));
      check({tag, "_dataarr1"},  int'(s_d1), int'(e.wr_op && e.way == 1));
      check({tag, "_dirtywr0"},  int'(s_y0), int'(e.wr_op && e.way == 0));
      check({tag, "_dirtywr1"},  int'(s_y1), int'(e.wr_op && e.way == 1));
      check({tag, "_pmem_idle"}, int'(s_pm), 0);
      check({tag, "_hit_count"},  int'(hit_count),  e.hits);
      check({tag, "_miss_count"}, int'(miss_count), e.misses);
      check_arrays(tag);
   endtask

   // Read miss whose request is withdrawn once the memory fetch has begun.
   task automatic do_abandon(input string tag, input logic [7:0] ctag, input int lat);
      exp_t e;
      int   c, rd0, wr0, f00, f10, rs0;
      e = '{lat: 0, rd: 0, wr: 0, wb_sel: 0, fill_way: -1, way: 0, wr_op: 1'b0, hits: 0, misses: 0};
      ref_miss_fill(e, ctag, 1'b0, lat);
      e.hits   = ref_hit;
      e.misses = ref_miss;
      exp_q.push_back(e);

      rd0 = rd_cyc; wr0 = wr_cyc; f00 = fill0; f10 = fill1; rs0 = resp_cnt;
      mem_lat = lat;
      @(posedge clk); #1;
      mem_read = 1'b1; cpu_tag = ctag;
      c = 0;
      while (!pmem_read && c < 100) begin @(negedge clk); c++; end
      @(posedge clk); #1;
      mem_read = 1'b0;
      c = 0;
      while (pmem_read && c < 100) begin @(negedge clk); c++; end
      repeat (3) @(posedge clk);
      #1;

      e = exp_q.pop_front();
      check({tag, "_no_resp"},   resp_cnt - rs0, 0);
      check({tag, "_rd_cycles"}, rd_cyc - rd0, e.rd);
      check({tag, "_wr_cycles"}, wr_cyc - wr0, e.wr);
      check({tag, "_fill0"}, fill0 - f00, (e.fill_way == 0) ? 1 : 0);
      check({tag, "_fill1"}, fill1 - f10, (e.fill_way == 1) ? 1 : 0);
      check({tag, "_pmem_idle"}, int'(pmem_read | pmem_write), 0);
      check({tag, "_hit_count"},  int'(hit_count),  e.hits);
      check({tag, "_miss_count"}, int'(miss_count), e.misses);
      check_arrays(tag);
   endtask

   // Clean read miss interrupted by reset while the fetch is in flight.
   task automatic do_reset_mid_alloc(input string tag, input logic [7:0] ctag);
      int c;
      mem_lat = 4;
      @(posedge clk); #1;
      mem_read = 1'b1; cpu_tag = ctag;
      c = 0;
      while (!pmem_read && c < 100) begin @(negedge clk); c++; end
      check({tag, "_alloc_reached"}, int'(pmem_read), 1);
      #2;
      reset_n = 1'b0;
      #1;
      check({tag, "_pmem_read"},  int'(pmem_read), 0);
      check({tag, "_pmem_write"}, int'(pmem_write), 0);
      check({tag, "_mem_resp"},   int'(mem_resp), 0);
      check({tag, "_fill_strb"},  int'(tag0_write | tag1_write), 0);
      check({tag, "_hit_count"},  int'(hit_count), 0);
      check({tag, "_miss_count"}, int'(miss_count), 0);
      ref_hit  = 0;
      ref_miss = 0;
      mem_read = 1'b0;
      @(posedge clk); #1;
      reset_n = 1'b1;
   endtask

   initial begin
      // Reset state with a request already present on the inputs.
      mem_read = 1'b1;
      repeat (2) @(negedge clk);
      check("rst_mem_resp",   int'(mem_resp), 0);
      check("rst_pmem_read",  int'(pmem_read), 0);
      check("rst_pmem_write", int'(pmem_write), 0);
      check("rst_hit_count",  int'(hit_count), 0);
      check("rst_miss_count", int'(miss_count), 0);
      mem_read = 1'b0;
      @(posedge clk); #1;
      reset_n = 1'b1;

      do_req("clean_rd_miss", 1'b1, 1'b0, 8'h11, 3);
      do_req("rd_hit_w0",     1'b1, 1'b0, 8'h11, 2);
      do_req("clean_wr_miss", 1'b0, 1'b1, 8'h22, 2);
      do_req("rd_hit_w1",     1'b1, 1'b0, 8'h22, 2);
      do_req("rd_hit_w0b",    1'b1, 1'b0, 8'h11, 2);
      do_req("dirty_wr_miss", 1'b0, 1'b1, 8'h33, 3);
      do_req("rdwr_hit",      1'b1, 1'b1, 8'h11, 2);
      do_abandon("abandon", 8'h44, 2);
      do_reset_mid_alloc("rst_alloc", 8'h55);
      do_req("post_rst_hit",  1'b1, 1'b0, 8'h11, 2);
      do_req("rd_hit_w1b",    1'b1, 1'b0, 8'h44, 2);
      do_req("dirty_w0_miss", 1'b0, 1'b1, 8'h66, 2);
      for (int i = 0; i < 3; i++) do_req("sat_hit", 1'b1, 1'b0, 8'h66, 2);
      check("sat_hit_count", int'(hit_count), CNT_SAT);

      check("pmem_overlap",   both_cyc, 0);
      check("alloc_sel",      rd_sel_bad, 0);
      check("fill_strobes",   fill_bad, 0);
      check("scoreboard_end", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
